// File: rtl/clock_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clock_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int unsigned MIN_RATIO    = 32'd2;
    localparam int unsigned PERIOD_CNT_W = 32'd16;

endpackage

// File: rtl/clock_div_prog_if.sv
// Ratio request handshake and divided-clock outputs of clock_div_prog.
interface clock_div_prog_if #(
    parameter int RATIO_W = 8
) ();

    logic [RATIO_W-1:0] ratio_in;
    logic               ratio_valid;
    logic               ratio_ready;
    logic               clk_out;
    logic               tick;
    logic               running;
    logic               ratio_err;

    modport master (
        output ratio_in,
        output ratio_valid,
        input  ratio_ready,
        input  clk_out,
        input  tick,
        input  running,
        input  ratio_err
    );

    modport slave (
        input  ratio_in,
        input  ratio_valid,
        output ratio_ready,
        output clk_out,
        output tick,
        output running,
        output ratio_err
    );

endinterface

// File: rtl/clock_div_period_cnt.sv
// Period counter, wrap detect and registered clk_out/tick decode.
// Optional period counter output enabled by CLOCK_DIV_PROG_PERIOD_CNT_EN.
module clock_div_period_cnt
    import clock_div_pkg::*;
#(
    parameter int RATIO_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_s,
    input  logic [RATIO_W-1:0] ratio_s,
    input  logic               run_nxt_s,
    input  logic               restart_s,
    input  logic [RATIO_W-1:0] ratio_nxt_s,
    output logic               wrap_s,
    output logic               clk_out,
    output logic               tick
`ifdef CLOCK_DIV_PROG_PERIOD_CNT_EN
    ,
    output logic [PERIOD_CNT_W-1:0] period_cnt
`endif
);

    localparam logic [RATIO_W-1:0] ZERO_C = {RATIO_W{1'b0}};
    localparam logic [RATIO_W-1:0] ONE_C  = {{(RATIO_W-1){1'b0}}, 1'b1};

    logic [RATIO_W-1:0] cnt_r;
    logic [RATIO_W-1:0] cnt_nxt_s;
    logic [RATIO_W-1:0] half_s;
    logic               clk_out_r;
    logic               clk_out_nxt_s;
    logic               tick_r;
    logic               tick_nxt_s;

    // Last cycle of the current period; ratio is at least 2 whenever running
    always_comb begin
        wrap_s = 1'b0;
        if (run_s && (cnt_r == (ratio_s - ONE_C))) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Next count and the outputs it implies, so clk_out/tick can be registered
    always_comb begin
        cnt_nxt_s     = ZERO_C;
        clk_out_nxt_s = 1'b0;
        tick_nxt_s    = 1'b0;
        half_s        = {1'b0, ratio_nxt_s[RATIO_W-1:1]};
        if (!run_nxt_s || restart_s || wrap_s) begin
            cnt_nxt_s = ZERO_C;
        end else begin
            cnt_nxt_s = cnt_r + ONE_C;
        end
        if (run_nxt_s) begin
            clk_out_nxt_s = (cnt_nxt_s < half_s);
            tick_nxt_s    = (cnt_nxt_s == ZERO_C);
        end else begin
            clk_out_nxt_s = 1'b0;
            tick_nxt_s    = 1'b0;
        end
    end

    // Counter and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= ZERO_C;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            clk_out_r <= clk_out_nxt_s;
            tick_r    <= tick_nxt_s;
        end
    end

    assign clk_out = clk_out_r;
    assign tick    = tick_r;

`ifdef CLOCK_DIV_PROG_PERIOD_CNT_EN
    logic [PERIOD_CNT_W-1:0] period_cnt_r;

    // Count delivered periods, wrapping naturally at the counter width
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_cnt_r <= {PERIOD_CNT_W{1'b0}};
        end else if (tick_r) begin
            period_cnt_r <= period_cnt_r + {{(PERIOD_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            period_cnt_r <= period_cnt_r;
        end
    end

    assign period_cnt = period_cnt_r;
`endif

endmodule

// File: rtl/clock_div_prog.sv
// Programmable clock divider: ratio handshake and IDLE/RUN/PEND control.
// Define CLOCK_DIV_PROG_PERIOD_CNT_EN to add the period_cnt output.
module clock_div_prog
    import clock_div_pkg::*;
#(
    parameter int RATIO_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    clock_div_prog_if.slave         bus
`ifdef CLOCK_DIV_PROG_PERIOD_CNT_EN
    ,
    output logic [PERIOD_CNT_W-1:0] period_cnt
`endif
);

    localparam logic [RATIO_W-1:0] ZERO_C = {RATIO_W{1'b0}};
    localparam logic [RATIO_W-1:0] ONE_C  = {{(RATIO_W-1){1'b0}}, 1'b1};
    localparam logic [RATIO_W-1:0] MIN_C  = RATIO_W'(MIN_RATIO);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [RATIO_W-1:0] act_ratio_r;
    logic [RATIO_W-1:0] act_ratio_nxt_s;
    logic [RATIO_W-1:0] hold_ratio_r;
    logic [RATIO_W-1:0] hold_ratio_nxt_s;
    logic [RATIO_W-1:0] req_ratio_s;
    logic               accept_s;
    logic               err_nxt_s;
    logic               restart_s;
    logic               wrap_s;
    logic               run_s;
    logic               run_nxt_s;
    logic               ready_r;
    logic               running_r;
    logic               err_r;

    // Handshake and N=1 clamp
    always_comb begin
        accept_s    = 1'b0;
        err_nxt_s   = 1'b0;
        req_ratio_s = bus.ratio_in;
        if (bus.ratio_valid && ready_r) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (bus.ratio_in == ONE_C) begin
            req_ratio_s = MIN_C;
            err_nxt_s   = accept_s;
        end else begin
            req_ratio_s = bus.ratio_in;
            err_nxt_s   = 1'b0;
        end
    end

    // Next state; a new ratio only takes effect on a period boundary
    always_comb begin
        state_nxt_s      = state_r;
        act_ratio_nxt_s  = act_ratio_r;
        hold_ratio_nxt_s = hold_ratio_r;
        restart_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && (req_ratio_s != ZERO_C)) begin
                    state_nxt_s     = RUN;
                    act_ratio_nxt_s = req_ratio_s;
                    restart_s       = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (accept_s) begin
                    state_nxt_s      = PEND;
                    hold_ratio_nxt_s = req_ratio_s;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            PEND: begin
                if (wrap_s) begin
                    hold_ratio_nxt_s = ZERO_C;
                    act_ratio_nxt_s  = hold_ratio_r;
                    if (hold_ratio_r == ZERO_C) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = PEND;
                end
            end
            default: begin
                state_nxt_s      = IDLE;
                act_ratio_nxt_s  = ZERO_C;
                hold_ratio_nxt_s = ZERO_C;
            end
        endcase
    end

    assign run_s     = (state_r != IDLE);
    assign run_nxt_s = (state_nxt_s != IDLE);

    // FSM state, ratio registers and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            act_ratio_r  <= ZERO_C;
            hold_ratio_r <= ZERO_C;
            ready_r      <= 1'b1;
            running_r    <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            act_ratio_r  <= act_ratio_nxt_s;
            hold_ratio_r <= hold_ratio_nxt_s;
            ready_r      <= (state_nxt_s != PEND);
            running_r    <= run_nxt_s;
            err_r        <= err_nxt_s;
        end
    end

    clock_div_period_cnt #(
        .RATIO_W (RATIO_W)
    ) u_period_cnt (
        .clk         (clk),
        .rst         (rst),
        .run_s       (run_s),
        .ratio_s     (act_ratio_r),
        .run_nxt_s   (run_nxt_s),
        .restart_s   (restart_s),
        .ratio_nxt_s (act_ratio_nxt_s),
        .wrap_s      (wrap_s),
        .clk_out     (bus.clk_out),
        .tick        (bus.tick)
`ifdef CLOCK_DIV_PROG_PERIOD_CNT_EN
        ,
        .period_cnt  (period_cnt)
`endif
    );

    assign bus.ratio_ready = ready_r;
    assign bus.running     = running_r;
    assign bus.ratio_err   = err_r;

endmodule

// File: tb/tb_clock_div_prog.sv
// Table-driven bench for clock_div_prog: per-cycle expectations go to a
// scoreboard queue when inputs are driven and are checked on the falling edge.
module tb_clock_div_prog;
    import clock_div_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    clock_div_prog_if #(.RATIO_W(8)) bus ();

`ifdef CLOCK_DIV_PROG_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    clock_div_prog #(.RATIO_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef CLOCK_DIV_PROG_PERIOD_CNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic ck;
        logic tk;
        logic rn;
        logic rd;
        logic er;
    } exp_t;

    typedef struct {
        logic       v;
        logic [7:0] n;
        exp_t       e;
        string      name;
    } vec_t;

    vec_t  tbl[$];
    exp_t  sb[$];
    string sbn[$];
    int    checks = 0;
    int    errors = 0;

    exp_t  exp_e;
    exp_t  got_e;
    string exp_n;

    // Scoreboard: compare each queued expectation on the falling edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_e = sb.pop_front();
            exp_n = sbn.pop_front();
            got_e = {bus.clk_out, bus.tick, bus.running, bus.ratio_ready, bus.ratio_err};
            checks++;
            if (got_e !== exp_e) begin
                errors++;
                $display("FAIL %s: ck/tk/rn/rd/er got %b required %b at %0t",
                         exp_n, got_e, exp_e, $time);
            end
        end
    end

    task automatic add(input logic v, input logic [7:0] n, input logic ck,
                       input logic tk, input logic rn, input logic rd,
                       input logic er, input string nm);
        vec_t x;
        x.v    = v;
        x.n    = n;
        x.e    = {ck, tk, rn, rd, er};
        x.name = nm;
        tbl.push_back(x);
    endtask

    task automatic add_idle(input logic v, input logic [7:0] n, input string nm);
        add(v, n, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, nm);
    endtask

    // Steady running with ratio n, starting at cnt=0
    task automatic add_periods(input int n, input int steps, input string nm);
        for (int k = 0; k < steps; k++) begin
            add(1'b0, 8'd0, ((k % n) < (n / 2)), ((k % n) == 0), 1'b1, 1'b1, 1'b0, nm);
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            bus.ratio_valid = tbl[i].v;
            bus.ratio_in    = tbl[i].n;
            sb.push_back(tbl[i].e);
            sbn.push_back(tbl[i].name);
        end
        @(negedge clk);
        #1;
        bus.ratio_valid = 1'b0;
        bus.ratio_in    = 8'd0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d left, required 0", sb.size());
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.ratio_valid = 1'b0;
        bus.ratio_in    = 8'd0;
        rst = 1'b0;
        #20;
        rst = 1'b1;
    endtask

    initial begin
        bus.ratio_valid = 1'b0;
        bus.ratio_in    = 8'd0;

        // Idle after reset, no request
        do_reset();
        for (int i = 0; i < 50; i++) add_idle(1'b0, 8'd0, "idle_after_reset");
        run_table();

        // N=4 from IDLE: 1100 repeating, first tick right after acceptance
        do_reset();
        add_idle(1'b1, 8'd4, "n4_req");
        add_periods(4, 12, "n4");
        run_table();

        // N=5: high 2, low 3
        do_reset();
        add_idle(1'b1, 8'd5, "n5_req");
        add_periods(5, 10, "n5");
        run_table();

        // N=6 running, request N=3 at cnt=1; a request while pending is ignored
        do_reset();
        add_idle(1'b1, 8'd6, "n6_req");
        add(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "n6_cnt0");
        add(1'b1, 8'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "n6_cnt1");
        add(1'b1, 8'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "n6_cnt2_pend");
        for (int i = 0; i < 3; i++) add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "n6_low_pend");
        add_periods(3, 4, "n3_after_n6");
        run_table();

        // N=1 clamps to 2 with ratio_err; then N=0 stops at the wrap
        do_reset();
        add_idle(1'b1, 8'd1, "n1_req");
        add(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "n1_err");
        add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "n1_as_n2_low");
        add(1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "n2_stop_req");
        add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "n2_stop_pend");
        add_idle(1'b1, 8'd0, "stopped_n0_ignored");
        for (int i = 0; i < 3; i++) add_idle(1'b0, 8'd0, "stays_idle");
        run_table();

        // Largest ratio: high 127, low 128, then next tick
        do_reset();
        add_idle(1'b1, 8'd255, "n255_req");
        add_periods(255, 257, "n255");
        run_table();

        // Reset at cnt=2 with N=8 and N=3 pending
        do_reset();
        add_idle(1'b1, 8'd8, "n8_req");
        add(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "n8_cnt0");
        add(1'b1, 8'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "n8_cnt1");
        add(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "n8_cnt2_pend");
        run_table();
        rst = 1'b0;
        #1;
        got_e = {bus.clk_out, bus.tick, bus.running, bus.ratio_ready, bus.ratio_err};
        checks++;
        if (got_e !== 5'b00010) begin
            errors++;
            $display("FAIL rst_async: ck/tk/rn/rd/er got %b required 00010", got_e);
        end
`ifdef CLOCK_DIV_PROG_PERIOD_CNT_EN
        checks++;
        if (period_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_period_cnt: got %0d required 0", period_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) add_idle(1'b0, 8'd0, "idle_after_mid_reset");
        run_table();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_div_prog.md
CLOCK_DIV_PROG -- requirements
Module: clock_div_prog

Interface
REQ-001 Parameter: RATIO_W, default 8, width of the division-ratio bus.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: ratio_in  input  RATIO_W  requested division ratio N.
REQ-005 Port: ratio_valid  input  1  ratio_in request valid.
REQ-006 Port: ratio_ready  output  1  block can accept a request.
REQ-007 Port: clk_out  output  1  registered divided clock.
REQ-008 Port: tick  output  1  one-cycle pulse marking the first cycle of each clk_out period.
REQ-009 Port: running  output  1  high while periods are being generated.
REQ-010 Port: ratio_err  output  1  one-cycle pulse when a request with N=1 is accepted.

Function
REQ-011 The handshake SHALL accept a request in a cycle where ratio_valid and ratio_ready are both high; all other cycles SHALL leave state unchanged.
REQ-012 The FSM SHALL use three states: IDLE (stopped), RUN (generating), PEND (RUN with an accepted ratio awaiting its period boundary).
REQ-013 ratio_ready SHALL be high in IDLE and RUN and low in PEND.
REQ-014 In IDLE, acceptance of N>=2 SHALL enter RUN; in the next cycle cnt=0, clk_out=1, tick=1.
REQ-015 In IDLE, acceptance of N=0 SHALL be ignored and SHALL keep the block in IDLE.
REQ-016 An accepted N=1 SHALL be clamped to 2 and SHALL pulse ratio_err in the cycle after acceptance.
REQ-017 Period counter cnt SHALL run 0..N-1 and wrap to 0.
REQ-018 clk_out SHALL be 1 for cnt in [0, floor(N/2)-1] and 0 otherwise; for odd N the low phase is one cycle longer.
REQ-019 tick SHALL equal 1 exactly in cycles with cnt=0 while running.
REQ-020 In RUN, acceptance SHALL enter PEND, and the new ratio SHALL be held.
REQ-021 In PEND, the held ratio SHALL take effect at the wrap (cnt=N_old-1 to 0), and the FSM SHALL return to RUN.
REQ-022 No clk_out high or low phase SHALL ever be shorter than the old or new ratio dictates (no runt pulses).
REQ-023 A pending N=0 SHALL, at the wrap, enter IDLE with clk_out=0 and tick=0, and no new period SHALL begin.
REQ-024 running SHALL be 1 in RUN and PEND and 0 in IDLE.
REQ-025 Ratio arithmetic SHALL be unsigned RATIO_W bits; N=2^RATIO_W-1 SHALL be supported without overflow.

Reset
REQ-026 Asserting rst low SHALL, asynchronously, set FSM=IDLE, cnt=0, active ratio=0, held ratio=0.
REQ-027 Reset SHALL set outputs clk_out=0, tick=0, running=0, ratio_err=0 and ratio_ready=1.
REQ-028 Reset mid-period or in PEND SHALL discard the pending ratio; after release the block SHALL stay IDLE until a new request.

Configuration
REQ-029 Macro CLOCK_DIV_PROG_PERIOD_CNT_EN defined SHALL add output period_cnt (16 bits), reset to 0, incremented on every tick and wrapping from 65535 to 0.
REQ-030 Without CLOCK_DIV_PROG_PERIOD_CNT_EN, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package clock_div_pkg SHALL hold the FSM state typedef (IDLE/RUN/PEND), the constant MIN_RATIO=2 and the constant PERIOD_CNT_W=16.
REQ-032 Sub-module clock_div_period_cnt SHALL contain cnt, the wrap detect and the clk_out/tick decode; clock_div_prog SHALL hold the FSM and handshake.

Verification
REQ-033 Bench SHALL check: rst low 20 ns then high, no request -> clk_out=0, running=0, ratio_ready=1 for 50 cycles.
REQ-034 Bench SHALL check: request N=4 from IDLE -> clk_out pattern 1100 repeating, tick every 4th cycle, first tick the cycle after acceptance.
REQ-035 Bench SHALL check: request N=5 -> high 2 cycles, low 3 cycles, period 5.
REQ-036 Bench SHALL check: running N=6, request N=3 at cnt=1 -> ratio_ready low until wrap, current period completes as 111000, next period is 100.
REQ-037 Bench SHALL check: request N=1 -> ratio_err single pulse, output runs as N=2; then request N=0 -> current period finishes, then IDLE with clk_out=0.
REQ-038 Bench SHALL check: rst asserted low at cnt=2 with N=8 and a pending N=3 -> outputs at reset values immediately; after release, stays IDLE; with CLOCK_DIV_PROG_PERIOD_CNT_EN, period_cnt=0.
